// File: rtl/exu_trap_cmt.sv
// Trap/mret commit unit: M-mode trap CSRs plus a two-state IDLE/FLUSH redirect FSM.
// Optional mtval CSR and cmt_tval port are enabled by defining EXU_TRAP_CMT_MTVAL_EN.
module exu_trap_cmt #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmt_trap_valid,
    output logic            cmt_trap_ready,
    input  logic [XLEN-1:0] cmt_cause,
    input  logic [XLEN-1:0] cmt_pc,
`ifdef EXU_TRAP_CMT_MTVAL_EN
    input  logic [XLEN-1:0] cmt_tval,
`endif
    input  logic            cmt_mret_valid,
    output logic            cmt_mret_ready,
    input  logic            csr_ena,
    input  logic            csr_wr_en,
    input  logic [11:0]     csr_idx,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            flush_req_valid,
    input  logic            flush_req_ready,
    output logic [XLEN-1:0] flush_pc,
    output logic            trap_busy
);

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t          state;
    logic            mie;
    logic            mpie;
    logic [1:0]      mpp;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
`ifdef EXU_TRAP_CMT_MTVAL_EN
    logic [XLEN-1:0] mtval;
`endif

    logic trap_acc;
    logic mret_acc;
    logic csr_wr;
    logic unused_pc_lsb;

    assign cmt_trap_ready  = (state == IDLE);
    assign cmt_mret_ready  = (state == IDLE) && !cmt_trap_valid;
    assign flush_req_valid = (state == FLUSH);
    assign trap_busy       = (state != IDLE);

    assign trap_acc      = cmt_trap_valid && cmt_trap_ready;
    assign mret_acc      = cmt_mret_valid && cmt_mret_ready;
    assign csr_wr        = csr_ena && csr_wr_en;
    assign unused_pc_lsb = ^cmt_pc[1:0];

    // Reads always show the current register contents, never the value being written.
    always_comb begin
        csr_rdata = '0;
        case (csr_idx)
            12'h300: csr_rdata = {{(XLEN-13){1'b0}}, mpp, 3'b000, mpie, 3'b000, mie, 3'b000};
            12'h305: csr_rdata = mtvec;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
`ifdef EXU_TRAP_CMT_MTVAL_EN
            12'h343: csr_rdata = mtval;
`endif
            default: csr_rdata = '0;
        endcase
    end

    // CSR writes are applied first so a same-cycle trap/mret update overrides them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mpp      <= 2'b11;
            mtvec    <= {RESET_MTVEC[XLEN-1:2], 2'b00};
            mepc     <= '0;
            mcause   <= '0;
            flush_pc <= '0;
`ifdef EXU_TRAP_CMT_MTVAL_EN
            mtval    <= '0;
`endif
        end else begin
            if (csr_wr) begin
                case (csr_idx)
                    12'h300: begin
                        mie  <= csr_wdata[3];
                        mpie <= csr_wdata[7];
                        mpp  <= csr_wdata[12:11];
                    end
                    12'h305: mtvec  <= {csr_wdata[XLEN-1:2], 2'b00};
                    12'h341: mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
                    12'h342: mcause <= csr_wdata;
`ifdef EXU_TRAP_CMT_MTVAL_EN
                    12'h343: mtval  <= csr_wdata;
`endif
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (trap_acc) begin
                        mepc     <= {cmt_pc[XLEN-1:2], 2'b00};
                        mcause   <= cmt_cause;
                        mpie     <= mie;
                        mie      <= 1'b0;
                        mpp      <= 2'b11;
                        flush_pc <= {mtvec[XLEN-1:2], 2'b00};
`ifdef EXU_TRAP_CMT_MTVAL_EN
                        mtval    <= cmt_tval;
`endif
                        state    <= FLUSH;
                    end else if (mret_acc) begin
                        mie      <= mpie;
                        mpie     <= 1'b1;
                        mpp      <= 2'b11;
                        flush_pc <= mepc;
                        state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_req_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
